// File: rtl/rr_wormhole_arbiter.sv
// Round-robin output-port arbiter with wormhole lock, selectable packet release and stall watchdog.
// One instance per router output port; drives the crossbar select.
module rr_wormhole_arbiter #(
  parameter int unsigned       NUM_IN       = 5,
  parameter int unsigned       TYPE_W       = 3,
  parameter int unsigned       LEN_W        = 12,
  parameter logic [TYPE_W-1:0] HEADER_CODE  = TYPE_W'(3'b001),
  parameter logic [TYPE_W-1:0] TAIL_CODE    = TYPE_W'(3'b100),
  parameter int unsigned       RELEASE_MODE = 2,
  parameter int unsigned       STALL_LIMIT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IN-1:0]          req,
  input  logic [NUM_IN*TYPE_W-1:0]   flit_type,
  input  logic [NUM_IN*LEN_W-1:0]    length,
  input  logic                       out_ready,
  output logic [NUM_IN-1:0]          grant,
  output logic [$clog2(NUM_IN)-1:0]  grant_idx,
  output logic                       idle,
  output logic                       xfer,
  output logic                       stall_release
);

  localparam int unsigned IDX_W   = $clog2(NUM_IN);
  localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     arb_base;
  logic [IDX_W-1:0]     arb_j;
  logic [IDX_W-1:0]     win;
  logic                 win_found;
  logic [LEN_W-1:0]     cnt;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     sel_len;
  logic [LEN_W-1:0]     cnt_post;
  logic [LEN_W-1:0]     len_post;
  logic [TYPE_W-1:0]    sel_type;
  logic [STALL_W-1:0]   stall_cnt;
  logic                 req_i;
  logic                 is_hdr;
  logic                 tail_hit;
  logic                 len_hit;
  logic                 pkt_rel;
  logic                 stall_hit;

  // While locked, the owner is the priority base so a release re-arbitrates with it lowest.
  assign arb_base = (state == S_LOCKED) ? grant_idx : ptr;

  always_comb begin : arbitrate
    win       = '0;
    win_found = 1'b0;
    arb_j     = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      arb_j = IDX_W'((32'(arb_base) + k) % NUM_IN);
      if (!win_found && req[arb_j]) begin
        win       = arb_j;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin : owner_mux
    sel_type = '0;
    sel_len  = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (grant[k]) begin
        sel_type = flit_type[k*TYPE_W +: TYPE_W];
        sel_len  = length[k*LEN_W +: LEN_W];
      end
    end
  end

  assign req_i = |(grant & req);
  assign xfer  = |(grant & req) & out_ready;
  assign is_hdr = (sel_type == HEADER_CODE);

  // A header restarts the count; a zero length field still describes a one-flit packet.
  always_comb begin : flit_count
    if (is_hdr) begin
      len_post = (sel_len == '0) ? LEN_W'(1) : sel_len;
      cnt_post = LEN_W'(1);
    end else begin
      len_post = len_q;
      cnt_post = (cnt == '1) ? cnt : cnt + LEN_W'(1);
    end
  end

  assign tail_hit  = (RELEASE_MODE != 1) && (sel_type == TAIL_CODE);
  assign len_hit   = (RELEASE_MODE != 0) && (cnt_post == len_post);
  assign pkt_rel   = xfer && (tail_hit || len_hit);
  assign stall_hit = (STALL_LIMIT != 0) && (state == S_LOCKED) && !req_i &&
                     (stall_cnt == STALL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= '0;
      grant_idx     <= '0;
      idle          <= 1'b1;
      stall_release <= 1'b0;
      ptr           <= IDX_W'(NUM_IN - 1);
      cnt           <= '0;
      len_q         <= '0;
      stall_cnt     <= '0;
    end else begin
      stall_release <= stall_hit;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state     <= S_LOCKED;
            grant     <= NUM_IN'(1) << win;
            grant_idx <= win;
            idle      <= 1'b0;
          end
        end
        S_LOCKED: begin
          if (xfer) begin
            cnt   <= cnt_post;
            len_q <= len_post;
          end
          if (req_i || (STALL_LIMIT == 0)) stall_cnt <= '0;
          else                             stall_cnt <= stall_cnt + STALL_W'(1);
          if (pkt_rel || stall_hit) begin
            ptr       <= grant_idx;
            cnt       <= '0;
            len_q     <= '0;
            stall_cnt <= '0;
            if (|req) begin
              grant     <= NUM_IN'(1) << win;
              grant_idx <= win;
            end else begin
              state     <= S_IDLE;
              grant     <= '0;
              grant_idx <= '0;
              idle      <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
